// File: rtl/otter_pkg.sv
// Shared OTTER definitions: control FSM states and base opcodes.
// Used by the control FSM and the combinational decoder.
package otter_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_INTR,
        ST_HALT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Opcodes that write rd and retire in a single EXEC cycle
    function automatic logic is_alu_or_jump(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    endfunction

endpackage

// File: rtl/otter_wait_timer.sv
// Memory wait-state counter for the OTTER control FSM.
// Counts cycles spent waiting for MEM_ACK; flags when MAX_WAIT is reached.
module otter_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] r_cnt;

    // Clear has priority so each waiting phase starts from zero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control FSM: init, fetch, execute, writeback, interrupt entry,
// plus a memory-ack watchdog that parks the core in ST_HALT on a stalled bus.
// Optional: define OTTER_INSTRET_EN to add a 32-bit retired-instruction counter.
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned MAX_WAIT    = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] OPCODE,
    input  logic [2:0] FUNC3,
    input  logic       INTR,
    input  logic       CSR_MIE,
    input  logic       MEM_ACK,
    output logic       PC_WRITE,
    output logic       REG_WRITE,
    output logic       MEM_RDEN1,
    output logic       MEM_RDEN2,
    output logic       MEM_WE2,
    output logic       CSR_WE,
    output logic       INT_TAKEN,
    output logic       MRET_EXEC,
    output logic       RESET,
    output logic       MEM_ERR
`ifdef OTTER_INSTRET_EN
    ,
    output logic [31:0] INSTRET
`endif
);

    localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_d;
    logic [INIT_W-1:0]   r_init_cnt;
    logic [INIT_W-1:0]   w_init_cnt_d;
    logic                r_mem_err;
    logic                w_waiting;
    logic                w_expired;
    logic                w_wait_inc;
    logic                w_timeout;
    state_t              w_retire_state;

    // Phases that stall on MEM_ACK and are guarded by the watchdog
    assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_WB) ||
                       ((r_state == ST_EXEC) && (OPCODE == OP_STORE));
    assign w_wait_inc = w_waiting && !MEM_ACK && !w_expired;
    assign w_timeout  = w_waiting && !MEM_ACK && w_expired;

    // Interrupts are only sampled when an instruction retires
    assign w_retire_state = (INTR && CSR_MIE) ? ST_INTR : ST_FETCH;

    otter_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_timer (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_clr    (!w_wait_inc),
        .i_inc    (w_wait_inc),
        .o_expired(w_expired)
    );

    // State register, init counter and sticky timeout flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_init_cnt <= w_init_cnt_d;
            r_mem_err  <= r_mem_err | w_timeout;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d    = r_state;
        w_init_cnt_d = r_init_cnt;
        unique case (r_state)
            ST_INIT: begin
                if (r_init_cnt == INIT_LAST) begin
                    w_state_d = ST_FETCH;
                end else begin
                    w_init_cnt_d = r_init_cnt + 1'b1;
                end
            end
            ST_FETCH: begin
                if (MEM_ACK) begin
                    w_state_d = ST_EXEC;
                end else if (w_expired) begin
                    w_state_d = ST_HALT;
                end
            end
            ST_EXEC: begin
                if (OPCODE == OP_LOAD) begin
                    w_state_d = ST_WB;
                end else if (OPCODE == OP_STORE) begin
                    if (MEM_ACK) begin
                        w_state_d = w_retire_state;
                    end else if (w_expired) begin
                        w_state_d = ST_HALT;
                    end
                end else begin
                    w_state_d = w_retire_state;
                end
            end
            ST_WB: begin
                if (MEM_ACK) begin
                    w_state_d = w_retire_state;
                end else if (w_expired) begin
                    w_state_d = ST_HALT;
                end
            end
            ST_INTR: w_state_d = ST_FETCH;
            ST_HALT: w_state_d = ST_HALT;
            default: w_state_d = ST_INIT;
        endcase
    end

    // Output decode from state, opcode and the ack of the current memory phase
    always_comb begin
        PC_WRITE  = 1'b0;
        REG_WRITE = 1'b0;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        CSR_WE    = 1'b0;
        INT_TAKEN = 1'b0;
        MRET_EXEC = 1'b0;
        RESET     = 1'b0;
        unique case (r_state)
            ST_INIT:  RESET = 1'b1;
            ST_FETCH: MEM_RDEN1 = 1'b1;
            ST_EXEC: begin
                if (OPCODE == OP_LOAD) begin
                    MEM_RDEN2 = 1'b1;
                end else if (OPCODE == OP_STORE) begin
                    MEM_WE2  = 1'b1;
                    PC_WRITE = MEM_ACK;
                end else if (OPCODE == OP_SYS) begin
                    PC_WRITE = 1'b1;
                    if (FUNC3 inside {3'b001, 3'b010, 3'b011}) begin
                        REG_WRITE = 1'b1;
                        CSR_WE    = 1'b1;
                    end else if (FUNC3 == 3'b000) begin
                        MRET_EXEC = 1'b1;
                    end
                end else begin
                    // Branches and unknown opcodes only advance the PC
                    PC_WRITE  = 1'b1;
                    REG_WRITE = is_alu_or_jump(OPCODE);
                end
            end
            ST_WB: begin
                REG_WRITE = MEM_ACK;
                PC_WRITE  = MEM_ACK;
            end
            ST_INTR: begin
                INT_TAKEN = 1'b1;
                PC_WRITE  = 1'b1;
            end
            ST_HALT: ;
            default: ;
        endcase
    end

    assign MEM_ERR = r_mem_err;

`ifdef OTTER_INSTRET_EN
    logic        w_retire;
    logic [31:0] r_instret;

    assign w_retire = PC_WRITE && ((r_state == ST_EXEC) || (r_state == ST_WB));

    // Retired-instruction counter; interrupt entry is not a retirement
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign INSTRET = r_instret;
`endif

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Bench for otter_cu_fsm: directed scenarios with literal expectations, then
// randomized traffic against a phase-level behavioural model.
module tb_otter_cu_fsm;

    localparam int INIT_CYCLES = 2;
    localparam int MAX_WAIT    = 15;

    localparam logic [6:0] ADD = 7'b0110011;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;

    // Model phases
    localparam int M_BOOT  = 0;
    localparam int M_FETCH = 1;
    localparam int M_EXEC  = 2;
    localparam int M_WB    = 3;
    localparam int M_IRQ   = 4;
    localparam int M_HALT  = 5;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [6:0] OPCODE = 7'd0;
    logic [2:0] FUNC3 = 3'd0;
    logic       INTR = 1'b0;
    logic       CSR_MIE = 1'b0;
    logic       MEM_ACK = 1'b0;
    logic       PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2;
    logic       CSR_WE, INT_TAKEN, MRET_EXEC, RESET, MEM_ERR;
`ifdef OTTER_INSTRET_EN
    logic [31:0] INSTRET;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    int          m_mode;
    int          m_boot_left;
    int          m_stall;
    bit          m_err;
    logic [31:0] m_instret;

    always #5 CLK = ~CLK;

    otter_cu_fsm #(
        .INIT_CYCLES(INIT_CYCLES),
        .MAX_WAIT   (MAX_WAIT)
    ) u_dut (
        .CLK      (CLK),
        .RST      (RST),
        .OPCODE   (OPCODE),
        .FUNC3    (FUNC3),
        .INTR     (INTR),
        .CSR_MIE  (CSR_MIE),
        .MEM_ACK  (MEM_ACK),
        .PC_WRITE (PC_WRITE),
        .REG_WRITE(REG_WRITE),
        .MEM_RDEN1(MEM_RDEN1),
        .MEM_RDEN2(MEM_RDEN2),
        .MEM_WE2  (MEM_WE2),
        .CSR_WE   (CSR_WE),
        .INT_TAKEN(INT_TAKEN),
        .MRET_EXEC(MRET_EXEC),
        .RESET    (RESET),
        .MEM_ERR  (MEM_ERR)
`ifdef OTTER_INSTRET_EN
        ,
        .INSTRET  (INSTRET)
`endif
    );

    task automatic model_reset();
        m_mode      = M_BOOT;
        m_boot_left = INIT_CYCLES;
        m_stall     = 0;
        m_err       = 1'b0;
        m_instret   = 32'd0;
    endtask

    // Expected {PC_WRITE,REG_WRITE,RDEN1,RDEN2,WE2,CSR_WE,INT_TAKEN,MRET,RESET,MEM_ERR}
    function automatic logic [9:0] model_out();
        bit pcw = 0, regw = 0, rd1 = 0, rd2 = 0, we2 = 0;
        bit csrwe = 0, intt = 0, mret = 0, rsto = 0;
        case (m_mode)
            M_BOOT:  rsto = 1;
            M_FETCH: rd1 = 1;
            M_EXEC: begin
                if (OPCODE == LW) rd2 = 1;
                else if (OPCODE == SW) begin
                    we2 = 1;
                    pcw = MEM_ACK;
                end else begin
                    pcw = 1;
                    if (OPCODE == 7'b1110011) begin
                        csrwe = (FUNC3 == 3'd1) || (FUNC3 == 3'd2) || (FUNC3 == 3'd3);
                        regw  = csrwe;
                        mret  = (FUNC3 == 3'd0);
                    end else begin
                        regw = (OPCODE == 7'b0110011) || (OPCODE == 7'b0010011) ||
                               (OPCODE == 7'b0110111) || (OPCODE == 7'b0010111) ||
                               (OPCODE == 7'b1101111) || (OPCODE == 7'b1100111);
                    end
                end
            end
            M_WB: begin
                pcw  = MEM_ACK;
                regw = MEM_ACK;
            end
            M_IRQ: begin
                intt = 1;
                pcw  = 1;
            end
            default: ;
        endcase
        return {pcw, regw, rd1, rd2, we2, csrwe, intt, mret, rsto, m_err};
    endfunction

    // Advance the model across one rising edge using the inputs held in that cycle
    task automatic model_step();
        logic [9:0] o;
        bit waiting;
        if (RST) begin
            model_reset();
            return;
        end
        o = model_out();
        waiting = (m_mode == M_FETCH) || (m_mode == M_WB) ||
                  ((m_mode == M_EXEC) && (OPCODE == SW));
        if (waiting && !MEM_ACK) begin
            m_stall++;
            if (m_stall > MAX_WAIT) begin
                m_mode = M_HALT;
                m_err  = 1'b1;
            end
        end else begin
            m_stall = 0;
            if ((m_mode == M_EXEC || m_mode == M_WB) && o[9]) begin
                m_instret = m_instret + 32'd1;
                m_mode = (INTR && CSR_MIE) ? M_IRQ : M_FETCH;
            end else begin
                case (m_mode)
                    M_BOOT: begin
                        m_boot_left--;
                        if (m_boot_left == 0) m_mode = M_FETCH;
                    end
                    M_FETCH: m_mode = M_EXEC;
                    M_EXEC:  if (OPCODE == LW) m_mode = M_WB;
                    M_IRQ:   m_mode = M_FETCH;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic compare();
        logic [9:0] exp_v;
        logic [9:0] got_v;
        if (RST) model_reset();
        exp_v = model_out();
        got_v = {PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
                 CSR_WE, INT_TAKEN, MRET_EXEC, RESET, MEM_ERR};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL outputs t=%0t mode=%0d op=%b: got %b expected %b",
                     $time, m_mode, OPCODE, got_v, exp_v);
        end
`ifdef OTTER_INSTRET_EN
        n_cmp++;
        if (INSTRET !== m_instret) begin
            n_bad++;
            $display("FAIL instret t=%0t: got %0d expected %0d", $time, INSTRET, m_instret);
        end
`endif
    endtask

    task automatic chk(input string name, input logic got, input logic exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %b expected %b", name, $time, got, exp_v);
        end
    endtask

    // One clock cycle: step model at the edge, drive at the falling edge, then check
    task automatic cyc(input bit rst, input logic [6:0] op, input logic [2:0] f3,
                       input bit intr, input bit mie, input bit ack);
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        RST = rst; OPCODE = op; FUNC3 = f3; INTR = intr; CSR_MIE = mie; MEM_ACK = ack;
        #1;
        compare();
    endtask

    task automatic do_reset();
        cyc(1, ADD, 3'd0, 0, 0, 0);
        cyc(0, ADD, 3'd0, 0, 0, 0);
        cyc(0, ADD, 3'd0, 0, 0, 0);
    endtask

    logic [6:0] op_tab [10] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1110011,
                                7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                                7'b1101111, 7'b1100111};

    initial begin
        int burst;
        logic [31:0] r;
        logic [6:0] rop;
        logic [2:0] rf3;
        bit rrst, rack, rint, rmie;
        model_reset();

        // Reset held 3 cycles, RESET for 2 cycles after release, then fetch
        cyc(1, ADD, 3'd0, 0, 0, 0);
        chk("rst_reset", RESET, 1'b1);
        chk("rst_rden1", MEM_RDEN1, 1'b0);
        cyc(1, ADD, 3'd0, 0, 0, 0);
        cyc(1, ADD, 3'd0, 0, 0, 0);
        cyc(0, ADD, 3'd0, 0, 0, 0);
        chk("init1_reset", RESET, 1'b1);
        cyc(0, ADD, 3'd0, 0, 0, 0);
        chk("init2_reset", RESET, 1'b1);
        cyc(0, ADD, 3'd0, 0, 0, 1);
        chk("fetch_reset", RESET, 1'b0);
        chk("fetch_rden1", MEM_RDEN1, 1'b1);

        // add with immediate ack
        cyc(0, ADD, 3'd0, 0, 0, 1);
        chk("add_regw", REG_WRITE, 1'b1);
        chk("add_pcw", PC_WRITE, 1'b1);
        cyc(0, LW, 3'd2, 0, 0, 1);
        chk("add_back_fetch", MEM_RDEN1, 1'b1);

        // lw: three wait cycles in writeback
        cyc(0, LW, 3'd2, 0, 0, 0);
        chk("lw_rden2", MEM_RDEN2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, LW, 3'd2, 0, 0, 0);
            chk("lw_wb_wait_regw", REG_WRITE, 1'b0);
        end
        cyc(0, LW, 3'd2, 0, 0, 1);
        chk("lw_wb_ack_regw", REG_WRITE, 1'b1);
        chk("lw_wb_ack_pcw", PC_WRITE, 1'b1);

        // sw with pending interrupt
        cyc(0, SW, 3'd2, 1, 1, 1);
        chk("sw_fetch", MEM_RDEN1, 1'b1);
        cyc(0, SW, 3'd2, 1, 1, 0);
        chk("sw_we2_wait", MEM_WE2, 1'b1);
        chk("sw_pcw_wait", PC_WRITE, 1'b0);
        cyc(0, SW, 3'd2, 1, 1, 1);
        chk("sw_we2_ack", MEM_WE2, 1'b1);
        chk("sw_pcw_ack", PC_WRITE, 1'b1);
        chk("sw_regw", REG_WRITE, 1'b0);
        cyc(0, SW, 3'd2, 1, 1, 0);
        chk("intr_taken", INT_TAKEN, 1'b1);
        chk("intr_pcw", PC_WRITE, 1'b1);
        chk("intr_regw", REG_WRITE, 1'b0);
        cyc(0, SW, 3'd2, 1, 1, 0);
        chk("intr_one_cycle", INT_TAKEN, 1'b0);
        chk("intr_to_fetch", MEM_RDEN1, 1'b1);

        // Fetch timeout after 16 unacknowledged cycles
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(0, ADD, 3'd0, 0, 0, 0);
            chk("to_wait_rden1", MEM_RDEN1, 1'b1);
            chk("to_wait_err", MEM_ERR, 1'b0);
        end
        cyc(0, ADD, 3'd0, 0, 0, 0);
        chk("to_err", MEM_ERR, 1'b1);
        chk("to_rden1_off", MEM_RDEN1, 1'b0);
        chk("to_pcw_off", PC_WRITE, 1'b0);
        cyc(0, ADD, 3'd0, 0, 0, 1);
        chk("halt_sticky", MEM_ERR, 1'b1);
        cyc(1, ADD, 3'd0, 0, 0, 0);
        chk("rst_clears_err", MEM_ERR, 1'b0);
        chk("rst_from_halt", RESET, 1'b1);

        // Reset in the middle of a store drops MEM_WE2 at once
        cyc(0, ADD, 3'd0, 0, 0, 0);
        cyc(0, ADD, 3'd0, 0, 0, 0);
        cyc(0, SW, 3'd0, 0, 0, 1);
        cyc(0, SW, 3'd0, 0, 0, 0);
        chk("sw_mid_we2", MEM_WE2, 1'b1);
        cyc(1, SW, 3'd0, 0, 0, 0);
        chk("sw_rst_we2", MEM_WE2, 1'b0);

        // Five retired instructions plus one interrupt entry
        cyc(0, ADD, 3'd0, 0, 0, 0);
        cyc(0, ADD, 3'd0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, ADD, 3'd0, 0, 1, 1);
            cyc(0, ADD, 3'd0, (k == 2), 1, 1);
            if (k == 2) begin
                cyc(0, ADD, 3'd0, 0, 1, 0);
                chk("cnt_intr", INT_TAKEN, 1'b1);
            end
        end
        cyc(0, ADD, 3'd0, 0, 0, 0);
`ifdef OTTER_INSTRET_EN
        n_cmp++;
        if (INSTRET !== 32'd5) begin
            n_bad++;
            $display("FAIL instret_five: got %0d expected 5", INSTRET);
        end
`endif

        // Randomized traffic
        burst = 0;
        for (int n = 0; n < 4000; n++) begin
            @(posedge CLK);
            model_step();
            if (m_mode == M_FETCH || m_mode == M_BOOT || m_mode == M_HALT) begin
                r = $urandom_range(0, 11);
                if (r < 10) begin
                    rop = op_tab[r];
                end else begin
                    r = $urandom();
                    rop = r[6:0];
                end
                r = $urandom();
                rf3 = r[2:0];
            end else begin
                rop = OPCODE;
                rf3 = FUNC3;
            end
            if (burst == 0 && $urandom_range(0, 399) == 0) burst = 20;
            rack = (burst > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (burst > 0) burst--;
            rrst = ($urandom_range(0, 249) == 0) || (m_mode == M_HALT && $urandom_range(0, 7) == 0);
            rint = ($urandom_range(0, 2) == 0);
            rmie = ($urandom_range(0, 1) == 0);
            @(negedge CLK);
            RST = rrst; OPCODE = rop; FUNC3 = rf3; INTR = rint; CSR_MIE = rmie; MEM_ACK = rack;
            #1;
            compare();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
